// File: rtl/pkt_write_arbiter_if.sv
// Bundle of handshake and data signals between the packet sources, the write
// arbiter and the downstream sink.
//   master : driven by the environment (sources + sink); observes arbiter outputs
//   slave  : the arbiter side
// Signals:
//   sp0_wrr1          mode select, 0 strict priority, 1 weighted round robin
//   weights_p         packed per-port WRR weights
//   ready/sop/eop/vld per-port packet-available flag and beat qualifiers
//   data_in_p         packed per-port beats
//   out_ready         sink accepts a beat this cycle
//   busy              packet transfer in progress
//   grant_port        index of the granted port
//   next_data         one-hot pop strobe to the granted port
//   selected_data_out registered output beat, qualified by out_vld/out_sop/out_eop
interface pkt_write_arbiter_if #(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned NUM_PORTS    = 16,
  parameter int unsigned WEIGHT_WIDTH = 4
);
  localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic                               sp0_wrr1;
  logic [NUM_PORTS*WEIGHT_WIDTH-1:0]  weights_p;
  logic [NUM_PORTS-1:0]               ready;
  logic [NUM_PORTS-1:0]               sop;
  logic [NUM_PORTS-1:0]               eop;
  logic [NUM_PORTS-1:0]               vld;
  logic [DATA_WIDTH*NUM_PORTS-1:0]    data_in_p;
  logic                               out_ready;
  logic                               busy;
  logic [PortW-1:0]                   grant_port;
  logic [NUM_PORTS-1:0]               next_data;
  logic [DATA_WIDTH-1:0]              selected_data_out;
  logic                               out_vld;
  logic                               out_sop;
  logic                               out_eop;

  modport master (
    output sp0_wrr1, weights_p, ready, sop, eop, vld, data_in_p, out_ready,
    input  busy, grant_port, next_data, selected_data_out, out_vld, out_sop, out_eop
  );

  modport slave (
    input  sp0_wrr1, weights_p, ready, sop, eop, vld, data_in_p, out_ready,
    output busy, grant_port, next_data, selected_data_out, out_vld, out_sop, out_eop
  );
endinterface

// File: rtl/pkt_write_arbiter.sv
// Packet write arbiter: selects one of NUM_PORTS packet sources (strict priority
// or weighted round robin) and forwards the whole packet beat by beat to a single
// registered output.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-low reset
//   bus  pkt_write_arbiter_if.slave (mode, weights, per-port beats, sink handshake,
//        grant/busy status, pop strobes, registered output beat)
module pkt_write_arbiter #(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned NUM_PORTS    = 16,
  parameter int unsigned WEIGHT_WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  pkt_write_arbiter_if.slave bus
);
  localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {StIdle, StReload, StXfer} state_e;

  state_e                                 state_q, state_d;
  logic [PortW-1:0]                       grant_q, grant_d;
  logic [PortW-1:0]                       ptr_q, ptr_d;
  logic                                   mode_q, mode_d;  // mode latched at selection
  logic [NUM_PORTS-1:0][WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [DATA_WIDTH-1:0]                  data_q, data_d;
  logic                                   out_vld_q, out_vld_d;
  logic                                   out_sop_q, out_sop_d;
  logic                                   out_eop_q, out_eop_d;

  // Winner selection
  logic                   sp_found;
  logic [PortW-1:0]       sp_idx;
  logic [NUM_PORTS-1:0]   cand;
  logic [2*NUM_PORTS-1:0] cand_rot2;
  logic                   wrr_found;
  logic [PortW-1:0]       wrr_idx;
  logic [PortW:0]         wrr_sum;

  always_comb begin
    sp_found = 1'b0;
    sp_idx   = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!sp_found && bus.ready[j]) begin
        sp_found = 1'b1;
        sp_idx   = PortW'(j);
      end
    end

    for (int j = 0; j < NUM_PORTS; j++) begin
      cand[j] = bus.ready[j] && (credit_q[j] != '0);
    end
    // Rotate so bit 0 is the port at ptr; the first set bit is the winner.
    cand_rot2 = {cand, cand} >> ptr_q;
    wrr_found = 1'b0;
    wrr_idx   = '0;
    wrr_sum   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!wrr_found && cand_rot2[i]) begin
        wrr_found = 1'b1;
        wrr_sum   = {1'b0, ptr_q} + (PortW+1)'(i);
        if (wrr_sum >= (PortW+1)'(NUM_PORTS)) begin
          wrr_sum = wrr_sum - (PortW+1)'(NUM_PORTS);
        end
        wrr_idx = wrr_sum[PortW-1:0];
      end
    end
  end

  // Granted port's beat and qualifiers
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_vld, sel_sop, sel_eop;
  logic [WEIGHT_WIDTH-1:0] sel_credit;

  always_comb begin
    sel_data   = '0;
    sel_vld    = 1'b0;
    sel_sop    = 1'b0;
    sel_eop    = 1'b0;
    sel_credit = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (grant_q == PortW'(j)) begin
        sel_data   = bus.data_in_p[j*DATA_WIDTH +: DATA_WIDTH];
        sel_vld    = bus.vld[j];
        sel_sop    = bus.sop[j];
        sel_eop    = bus.eop[j];
        sel_credit = credit_q[j];
      end
    end
  end

  logic accept;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    mode_d        = mode_q;
    credit_d      = credit_q;
    data_d        = data_q;
    out_vld_d     = 1'b0;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    accept        = 1'b0;
    bus.next_data = '0;

    unique case (state_q)
      StIdle: begin
        if (|bus.ready) begin
          if (!bus.sp0_wrr1) begin
            state_d = StXfer;
            grant_d = sp_idx;
            mode_d  = 1'b0;
          end else if (wrr_found) begin
            state_d = StXfer;
            grant_d = wrr_idx;
            mode_d  = 1'b1;
          end else begin
            state_d = StReload;
          end
        end
      end
      StReload: begin
        for (int j = 0; j < NUM_PORTS; j++) begin
          credit_d[j] = (bus.weights_p[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0) ?
                        WEIGHT_WIDTH'(1) : bus.weights_p[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
        state_d = StIdle;
      end
      StXfer: begin
        accept = sel_vld && bus.out_ready;
        if (accept) begin
          bus.next_data = NUM_PORTS'(1) << grant_q;
          data_d        = sel_data;
          out_vld_d     = 1'b1;
          out_sop_d     = sel_sop;
          out_eop_d     = sel_eop;
          if (sel_eop) begin
            state_d = StIdle;
            if (mode_q) begin
              for (int j = 0; j < NUM_PORTS; j++) begin
                if (grant_q == PortW'(j)) begin
                  credit_d[j] = credit_q[j] - WEIGHT_WIDTH'(1);
                end
              end
              // Port exhausted its credit: move the scan start past it.
              if (sel_credit == WEIGHT_WIDTH'(1)) begin
                ptr_d = (grant_q == PortW'(NUM_PORTS-1)) ? '0 : grant_q + 1'b1;
              end else begin
                ptr_d = grant_q;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      mode_q    <= 1'b0;
      credit_q  <= '0;
      data_q    <= '0;
      out_vld_q <= 1'b0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      mode_q    <= mode_d;
      credit_q  <= credit_d;
      data_q    <= data_d;
      out_vld_q <= out_vld_d;
      out_sop_q <= out_sop_d;
      out_eop_q <= out_eop_d;
    end
  end

  assign bus.busy              = (state_q == StXfer);
  assign bus.grant_port        = grant_q;
  assign bus.selected_data_out = data_q;
  assign bus.out_vld           = out_vld_q;
  assign bus.out_sop           = out_sop_q;
  assign bus.out_eop           = out_eop_q;
endmodule

// File: tb/tb_pkt_write_arbiter.sv
// Directed bench for pkt_write_arbiter: strict priority, WRR ordering with
// reloads, backpressure, pointer wrap, mode switch during a packet and reset
// mid-packet. Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, away from the active edge.
module tb_pkt_write_arbiter;
  localparam int unsigned DW = 256;
  localparam int unsigned NP = 16;
  localparam int unsigned WW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pkt_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .WEIGHT_WIDTH(WW)) bus ();

  pkt_write_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .WEIGHT_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int p, input logic v, input logic s, input logic e,
                          input logic [DW-1:0] d);
    bus.vld[p] = v;
    bus.sop[p] = s;
    bus.eop[p] = e;
    bus.data_in_p[p*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Waits for the next grant counting non-busy cycles, then checks a single-beat
  // packet from that port passes through.
  task automatic next_grant(input string tag, input int port, input int gap,
                            input logic [DW-1:0] d);
    int n = 0;
    logic [NP-1:0] exp_nd;
    exp_nd = 16'h1 << port;
    while (bus.busy !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    check({tag, "_gap"}, 256'(n), 256'(gap));
    check({tag, "_grant"}, 256'(bus.grant_port), 256'(port));
    check({tag, "_next_data"}, 256'(bus.next_data), 256'(exp_nd));
    tick();
    check({tag, "_out_vld"}, 256'(bus.out_vld), 256'(1));
    check({tag, "_data"}, bus.selected_data_out, d);
  endtask

  initial begin
    bus.sp0_wrr1  = 1'b0;
    bus.weights_p = '0;
    bus.ready     = '0;
    bus.sop       = '0;
    bus.eop       = '0;
    bus.vld       = '0;
    bus.data_in_p = '0;
    bus.out_ready = 1'b1;

    // Reset values
    #2;
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_grant", 256'(bus.grant_port), 256'(0));
    check("rst_next_data", 256'(bus.next_data), 256'(0));
    check("rst_out_vld", 256'(bus.out_vld), 256'(0));
    check("rst_out_sop", 256'(bus.out_sop), 256'(0));
    check("rst_out_eop", 256'(bus.out_eop), 256'(0));
    check("rst_data", bus.selected_data_out, 256'(0));
    tick();
    rst = 1'b1;

    // Strict priority: port 1 three beats, then port 4
    bus.ready = 16'h0012;
    set_beat(1, 1, 1, 0, 256'hB0);
    check("sp_idle_next_data", 256'(bus.next_data), 256'(0));
    tick();
    check("sp_busy", 256'(bus.busy), 256'(1));
    check("sp_grant", 256'(bus.grant_port), 256'(1));
    check("sp_nd0", 256'(bus.next_data), 256'(16'h0002));
    check("sp_vld_lat", 256'(bus.out_vld), 256'(0));
    tick();
    set_beat(1, 1, 0, 0, 256'hB1);
    check("sp_out0_vld", 256'(bus.out_vld), 256'(1));
    check("sp_out0_sop", 256'(bus.out_sop), 256'(1));
    check("sp_out0_data", bus.selected_data_out, 256'hB0);
    check("sp_nd1", 256'(bus.next_data), 256'(16'h0002));
    tick();
    set_beat(1, 1, 0, 1, 256'hB2);
    check("sp_out1_data", bus.selected_data_out, 256'hB1);
    check("sp_nd2", 256'(bus.next_data), 256'(16'h0002));
    tick();
    check("sp_end_busy", 256'(bus.busy), 256'(0));
    check("sp_end_nd", 256'(bus.next_data), 256'(0));
    check("sp_out2_data", bus.selected_data_out, 256'hB2);
    check("sp_out2_eop", 256'(bus.out_eop), 256'(1));
    bus.ready = 16'h0010;
    set_beat(1, 0, 0, 0, 256'h0);
    set_beat(4, 1, 1, 1, 256'hC4);
    tick();
    check("sp_p4_grant", 256'(bus.grant_port), 256'(4));
    check("sp_p4_nd", 256'(bus.next_data), 256'(16'h0010));
    check("sp_p4_vld_gap", 256'(bus.out_vld), 256'(0));
    tick();
    check("sp_p4_busy", 256'(bus.busy), 256'(0));
    check("sp_p4_data", bus.selected_data_out, 256'hC4);
    bus.ready = '0;
    set_beat(4, 0, 0, 0, 256'h0);
    tick();

    // WRR order 0,0,1 per round with a reload between rounds
    do_reset();
    bus.sp0_wrr1  = 1'b1;
    bus.weights_p = '0;
    bus.weights_p[3:0] = 4'd2;
    bus.weights_p[7:4] = 4'd1;
    bus.ready = 16'h0003;
    set_beat(0, 1, 1, 1, 256'hA0);
    set_beat(1, 1, 1, 1, 256'hA1);
    next_grant("wrr_r1a", 0, 3, 256'hA0);
    next_grant("wrr_r1b", 0, 1, 256'hA0);
    next_grant("wrr_r1c", 1, 1, 256'hA1);
    next_grant("wrr_r2a", 0, 3, 256'hA0);
    next_grant("wrr_r2b", 0, 1, 256'hA0);
    next_grant("wrr_r2c", 1, 1, 256'hA1);
    bus.ready = '0;
    set_beat(0, 0, 0, 0, 256'h0);
    set_beat(1, 0, 0, 0, 256'h0);
    tick();

    // Backpressure: four beats from port 2, out_ready low on XFER cycles 2 and 3
    bus.sp0_wrr1 = 1'b0;
    bus.ready = 16'h0004;
    set_beat(2, 1, 1, 0, 256'hD0);
    tick();
    check("bp_grant", 256'(bus.grant_port), 256'(2));
    check("bp_nd_x1", 256'(bus.next_data), 256'(16'h0004));
    tick();
    set_beat(2, 1, 0, 0, 256'hD1);
    bus.out_ready = 1'b0;
    #1;
    check("bp_nd_x2", 256'(bus.next_data), 256'(0));
    check("bp_out_d0", bus.selected_data_out, 256'hD0);
    tick();
    check("bp_nd_x3", 256'(bus.next_data), 256'(0));
    check("bp_vld_hole", 256'(bus.out_vld), 256'(0));
    check("bp_hold", bus.selected_data_out, 256'hD0);
    check("bp_busy_x3", 256'(bus.busy), 256'(1));
    tick();
    bus.out_ready = 1'b1;
    #1;
    check("bp_nd_x4", 256'(bus.next_data), 256'(16'h0004));
    tick();
    set_beat(2, 1, 0, 0, 256'hD2);
    check("bp_out_d1", bus.selected_data_out, 256'hD1);
    check("bp_vld_d1", 256'(bus.out_vld), 256'(1));
    tick();
    set_beat(2, 1, 0, 1, 256'hD3);
    check("bp_out_d2", bus.selected_data_out, 256'hD2);
    check("bp_busy_x6", 256'(bus.busy), 256'(1));
    tick();
    check("bp_end_busy", 256'(bus.busy), 256'(0));
    check("bp_out_d3", bus.selected_data_out, 256'hD3);
    check("bp_out_eop", 256'(bus.out_eop), 256'(1));
    bus.ready = '0;
    set_beat(2, 0, 0, 0, 256'h0);
    tick();
    check("bp_idle_vld", 256'(bus.out_vld), 256'(0));

    // Pointer wrap 15 -> 0, all weights 1
    do_reset();
    bus.sp0_wrr1  = 1'b1;
    bus.weights_p = {16{4'h1}};
    bus.ready = 16'h4000;
    set_beat(14, 1, 1, 1, 256'hE14);
    next_grant("wrap_p14", 14, 3, 256'hE14);
    bus.ready = 16'h8001;
    set_beat(14, 0, 0, 0, 256'h0);
    set_beat(15, 1, 1, 1, 256'hE15);
    set_beat(0, 1, 1, 1, 256'hE00);
    next_grant("wrap_p15", 15, 1, 256'hE15);
    next_grant("wrap_p0", 0, 1, 256'hE00);
    next_grant("wrap_reload", 15, 3, 256'hE15);
    bus.ready = '0;
    set_beat(15, 0, 0, 0, 256'h0);
    set_beat(0, 0, 0, 0, 256'h0);
    tick();

    // Mode switch SP -> WRR during a packet
    do_reset();
    bus.sp0_wrr1 = 1'b0;
    bus.ready = 16'h0002;
    set_beat(1, 1, 1, 0, 256'hF0);
    tick();
    check("ms_grant", 256'(bus.grant_port), 256'(1));
    bus.sp0_wrr1 = 1'b1;
    tick();
    set_beat(1, 1, 0, 1, 256'hF1);
    check("ms_grant_hold", 256'(bus.grant_port), 256'(1));
    check("ms_nd", 256'(bus.next_data), 256'(16'h0002));
    tick();
    check("ms_end_busy", 256'(bus.busy), 256'(0));
    check("ms_end_data", bus.selected_data_out, 256'hF1);
    set_beat(1, 1, 1, 1, 256'hF2);
    next_grant("ms_wrr", 1, 3, 256'hF2);

    // Reset in the middle of a packet from port 3
    bus.ready = 16'h0008;
    set_beat(1, 0, 0, 0, 256'h0);
    set_beat(3, 1, 1, 0, 256'h30);
    begin
      int n = 0;
      while (bus.busy !== 1'b1 && n < 20) begin
        n++;
        tick();
      end
    end
    check("rm_grant", 256'(bus.grant_port), 256'(3));
    tick();
    set_beat(3, 1, 0, 0, 256'h31);
    check("rm_busy_pre", 256'(bus.busy), 256'(1));
    check("rm_vld_pre", 256'(bus.out_vld), 256'(1));
    rst = 1'b0;
    #1;
    check("rm_busy", 256'(bus.busy), 256'(0));
    check("rm_grant0", 256'(bus.grant_port), 256'(0));
    check("rm_nd", 256'(bus.next_data), 256'(0));
    check("rm_vld", 256'(bus.out_vld), 256'(0));
    check("rm_sop", 256'(bus.out_sop), 256'(0));
    check("rm_data", bus.selected_data_out, 256'(0));
    tick();
    rst = 1'b1;
    bus.ready = 16'h0001;
    set_beat(3, 0, 0, 0, 256'h0);
    set_beat(0, 1, 1, 1, 256'h40);
    next_grant("rm_after", 0, 3, 256'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_write_arbiter.md
PKT_WRITE_ARBITER -- requirements
Module: pkt_write_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 256, beat width; NUM_PORTS, default 16, input port count (>=2); WEIGHT_WIDTH, default 4, WRR weight width.
REQ-002 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- sp0_wrr1  in  1  mode select: 0 strict priority, 1 weighted round robin.
- weights_p  in  NUM_PORTS*WEIGHT_WIDTH  packed per-port WRR weights, port j at [(j+1)*WEIGHT_WIDTH-1 : j*WEIGHT_WIDTH].
- ready  in  NUM_PORTS  port j holds at least one complete packet.
- sop  in  NUM_PORTS  port j current beat is first of packet.
- eop  in  NUM_PORTS  port j current beat is last of packet.
- vld  in  NUM_PORTS  port j current beat valid.
- data_in_p  in  DATA_WIDTH*NUM_PORTS  packed beats, port j at [(j+1)*DATA_WIDTH-1 : j*DATA_WIDTH].
- out_ready  in  1  downstream accepts a beat this cycle.
- busy  out  1  packet transfer in progress.
- grant_port  out  $clog2(NUM_PORTS)  index of granted port.
- next_data  out  NUM_PORTS  one-hot pop strobe to the granted port, combinational.
- selected_data_out  out  DATA_WIDTH  registered output beat.
- out_vld, out_sop, out_eop  out  1 each  registered qualifiers of selected_data_out.

Function
REQ-003 SHALL implement FSM states IDLE, RELOAD, XFER; busy = (state == XFER).
REQ-004 IDLE: any ready bit set and a candidate exists -> register winner into grant_port, go XFER next cycle; none set -> stay IDLE.
REQ-005 Mode SHALL be sampled only in IDLE at selection; sp0_wrr1 changes during XFER SHALL not affect the current packet.
REQ-006 SP mode: winner = lowest index j with ready[j]=1; WRR state SHALL remain unchanged.
REQ-007 WRR mode: candidates = ready[j] & (credit[j] != 0); winner = first candidate found scanning upward from pointer ptr with wrap at NUM_PORTS-1 -> 0.
REQ-008 WRR: ready nonzero but no candidate -> go RELOAD; RELOAD loads credit[j] = weights[j] for all j (weight 0 loaded as 1), returns to IDLE next cycle.
REQ-009 XFER: beat accepted in cycles where vld[grant_port] & out_ready; next_data[grant_port] = 1 exactly in accept cycles; all other next_data bits 0; next_data all 0 outside XFER.
REQ-010 Accepted beat SHALL appear on selected_data_out with out_vld=1 and out_sop/out_eop copied from the port, one cycle after acceptance (latency 1); out_vld=0 in cycles following a non-accept; selected_data_out holds its last value when out_vld=0.
REQ-011 Accepted beat with eop=1 SHALL end the packet: state -> IDLE next cycle; single-beat packet (sop=eop=1) SHALL take one XFER cycle.
REQ-012 At packet end in WRR mode: credit[g] decrements by 1; if result is 0, ptr = (g+1) mod NUM_PORTS, else ptr = g. At packet end in SP mode, credits and ptr unchanged.
REQ-013 Changes to ready, sop of other ports, or ready[grant_port] during XFER SHALL be ignored; only vld/eop of the granted port and out_ready progress the transfer.
REQ-014 A new grant SHALL not be issued in the same cycle as eop acceptance; minimum gap between packets is one IDLE cycle.
REQ-015 grant_port SHALL be stable for the whole XFER.

Reset
REQ-016 rst=0 SHALL immediately force: state IDLE, busy 0, grant_port 0, next_data 0, out_vld/out_sop/out_eop 0, selected_data_out 0, ptr 0, all credits 0.
REQ-017 Reset assertion mid-packet SHALL abandon the packet; after release the arbiter SHALL re-arbitrate from IDLE, and first WRR selection SHALL pass through RELOAD.

Verification
REQ-018 SP: ready=16'h0012, port 1 sends 3 beats (eop on 3rd), out_ready=1 -> grant_port=1, next_data=16'h0002 for 3 cycles, out_vld 3 cycles delayed by 1, then port 4 granted.
REQ-019 WRR: weights port0=2, port1=1, others 0, ready=16'h0003, 1-beat packets -> grant order 0,0,1,0,0,1 with RELOAD cycles between rounds.
REQ-020 Backpressure: 4-beat packet, out_ready low on cycles 2 and 3 of XFER -> next_data low on those cycles, 4 out_vld pulses, data order preserved, busy held until eop accepted.
REQ-021 Wrap: WRR, ptr at 15, ready=16'h8001, weights 1 -> port 15 granted, then port 0; ptr wraps to 0.
REQ-022 Reset mid-packet: rst low during beat 2 of a 4-beat packet -> all outputs reset same cycle; after release with ready=16'h0001 in WRR mode -> RELOAD, then grant port 0.
REQ-023 Mode switch: sp0_wrr1 toggled 0->1 during XFER -> current packet completes unchanged; next selection uses WRR.
